// File: rtl/leorv32_lsu.sv
// Load/store unit for leorv32. Takes one decoded load or store per request and runs it
// on a 32-bit valid/ready data bus. Word-aligns the bus address, builds byte strobes,
// replicates store data across byte lanes, and extracts and extends load data.
// Misaligned accesses, illegal funct3 values and bus timeouts answer with resp_err.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   req_valid/req_ready        request handshake from the execute stage
//   req_store, req_funct3      access kind (load/store) and size/sign encoding
//   req_addr, req_wdata        byte address and store data (rs2)
//   resp_valid/resp_err        one-cycle completion pulse; error flag
//   resp_rdata                 extended load data, 0 for stores and errors
//   mem_valid/mem_ready        bus request handshake
//   mem_addr/mem_wdata/wstrb   word address, lane-replicated data, byte strobes (0 = read)
//   mem_rdata                  bus read data, valid with mem_ready
module leorv32_lsu #(
  parameter int unsigned BUS_TIMEOUT = 0  // BUS cycles without mem_ready before abort; 0 = never
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBus, StResp, StErr} state_e;

  localparam logic [31:0] TimeoutLast = 32'(BUS_TIMEOUT) - 32'd1;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        store_q, store_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;

  // Request decode
  logic        req_legal, req_misaligned, req_ok;
  logic [3:0]  req_strb;
  logic [31:0] req_wrep;

  always_comb begin
    if (req_store) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    // funct3[1:0] carries the access size for every legal encoding
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_ok = req_legal && !req_misaligned;

    req_strb = 4'b0000;
    req_wrep = 32'h0;
    if (req_store) begin
      case (req_funct3)
        3'b000: begin
          req_strb = 4'b0001 << req_addr[1:0];
          req_wrep = {4{req_wdata[7:0]}};
        end
        3'b001: begin
          req_strb = 4'b0011 << {req_addr[1], 1'b0};
          req_wrep = {2{req_wdata[15:0]}};
        end
        3'b010: begin
          req_strb = 4'b1111;
          req_wrep = req_wdata;
        end
        default: begin
          req_strb = 4'b0000;
          req_wrep = 32'h0;
        end
      endcase
    end
  end

  // Load data extraction from the addressed byte lane
  logic [31:0] ld_shift, ld_ext;

  always_comb begin
    ld_shift = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    store_d     = store_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          funct3_d    = req_funct3;
          off_d       = req_addr[1:0];
          store_d     = req_store;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_wdata_d = req_wrep;
          mem_wstrb_d = req_strb;
          cnt_d       = 32'h0;
          if (req_ok) begin
            state_d = StBus;
          end else begin
            state_d = StErr;
            rdata_d = 32'h0;
          end
        end
      end
      StBus: begin
        // mem_ready takes priority over a timeout expiring in the same cycle
        if (mem_ready) begin
          rdata_d = store_q ? 32'h0 : ld_ext;
          cnt_d   = 32'h0;
          state_d = StResp;
        end else if ((BUS_TIMEOUT != 0) && (cnt_q == TimeoutLast)) begin
          rdata_d = 32'h0;
          cnt_d   = 32'h0;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      store_q     <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      rdata_q     <= 32'h0;
      cnt_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      store_q     <= store_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    mem_valid  = (state_q == StBus);
    resp_valid = (state_q == StResp) || (state_q == StErr);
    resp_err   = (state_q == StErr);
    resp_rdata = rdata_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    mem_wstrb  = mem_wstrb_q;
  end

endmodule

// File: tb/tb_leorv32_lsu.sv
module tb_leorv32_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  leorv32_lsu #(
    .BUS_TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 10) begin
      step();
      n++;
    end
    check({tag, " req_ready wait"}, {31'h0, req_ready}, 32'h1);
  endtask

  // Successful access: bus fields checked, bus completes after 'delay' stalled cycles.
  task automatic access_ok(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_strb, input logic [31:0] exp_rdata);
    wait_ready(tag);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    req_valid = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      check({tag, " mem_valid"}, {31'h0, mem_valid}, 32'h1);
      check({tag, " req_ready busy"}, {31'h0, req_ready}, 32'h0);
      check({tag, " mem_addr"}, mem_addr, exp_addr);
      if (st) check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
      check({tag, " mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, exp_strb});
      check({tag, " no early resp"}, {31'h0, resp_valid}, 32'h0);
      if (i == delay) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      step();
    end
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_0000;
    check({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, " resp_err"}, {31'h0, resp_err}, 32'h0);
    check({tag, " resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, " mem_valid drop"}, {31'h0, mem_valid}, 32'h0);
    step();
    check({tag, " resp pulse"}, {31'h0, resp_valid}, 32'h0);
    check({tag, " rdata hold"}, resp_rdata, exp_rdata);
    check({tag, " idle"}, {31'h0, req_ready}, 32'h1);
  endtask

  // Access rejected before reaching the bus.
  task automatic access_err(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr);
    wait_ready(tag);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = 32'hFFFF_FFFF;
    step();
    req_valid = 1'b0;
    check({tag, " mem_valid"}, {31'h0, mem_valid}, 32'h0);
    check({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, " resp_err"}, {31'h0, resp_err}, 32'h1);
    check({tag, " resp_rdata"}, resp_rdata, 32'h0);
    step();
    check({tag, " mem_valid after"}, {31'h0, mem_valid}, 32'h0);
    check({tag, " resp pulse"}, {31'h0, resp_valid}, 32'h0);
    check({tag, " idle"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    step();
    step();
    check("rst req_ready", {31'h0, req_ready}, 32'h1);
    check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst resp_err", {31'h0, resp_err}, 32'h0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    check("rst mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    reset = 1'b0;
    step();

    // Loads from word 0x80AB_CDEF
    access_ok("lb",  1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80AB_CDEF,
              32'h0000_1000, 32'h0, 4'b0000, 32'hFFFF_FF80);
    access_ok("lbu", 1'b0, 3'b100, 32'h0000_1002, 32'h0, 0, 32'h80AB_CDEF,
              32'h0000_1000, 32'h0, 4'b0000, 32'h0000_00AB);
    access_ok("lhu", 1'b0, 3'b101, 32'h0000_1002, 32'h0, 1, 32'h80AB_CDEF,
              32'h0000_1000, 32'h0, 4'b0000, 32'h0000_80AB);
    access_ok("lh",  1'b0, 3'b001, 32'h0000_1002, 32'h0, 0, 32'h80AB_CDEF,
              32'h0000_1000, 32'h0, 4'b0000, 32'hFFFF_80AB);
    access_ok("lb0", 1'b0, 3'b000, 32'h0000_1000, 32'h0, 0, 32'h80AB_CDEF,
              32'h0000_1000, 32'h0, 4'b0000, 32'hFFFF_FFEF);
    // mem_ready after 3 stalled cycles lands on the timeout boundary and must still win
    access_ok("lw",  1'b0, 3'b010, 32'h0000_3000, 32'h0, 3, 32'h1122_3344,
              32'h0000_3000, 32'h0, 4'b0000, 32'h1122_3344);

    // Stores
    access_ok("sh",  1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 0, 32'hFFFF_FFFF,
              32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 32'h0);
    access_ok("sb",  1'b1, 3'b000, 32'h0000_2001, 32'h7777_775A, 2, 32'hFFFF_FFFF,
              32'h0000_2000, 32'h5A5A_5A5A, 4'b0010, 32'h0);
    access_ok("sw",  1'b1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF,
              32'h0000_2004, 32'hDEAD_BEEF, 4'b1111, 32'h0);

    // Misaligned and illegal encodings
    access_err("lw mis",  1'b0, 3'b010, 32'h0000_3001);
    access_err("lh mis",  1'b0, 3'b001, 32'h0000_3003);
    access_err("sw mis",  1'b1, 3'b010, 32'h0000_3002);
    access_err("ld 011",  1'b0, 3'b011, 32'h0000_3000);
    access_err("st 100",  1'b1, 3'b100, 32'h0000_3000);

    // Bus timeout: four mem_valid cycles, then an error pulse
    access_ok("lw pre", 1'b0, 3'b010, 32'h0000_4000, 32'h0, 0, 32'hCAFE_F00D,
              32'h0000_4000, 32'h0, 4'b0000, 32'hCAFE_F00D);
    wait_ready("tmo");
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_4000;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo mem_valid", {31'h0, mem_valid}, 32'h1);
      check("tmo no resp", {31'h0, resp_valid}, 32'h0);
      step();
    end
    check("tmo mem_valid drop", {31'h0, mem_valid}, 32'h0);
    check("tmo resp_valid", {31'h0, resp_valid}, 32'h1);
    check("tmo resp_err", {31'h0, resp_err}, 32'h1);
    check("tmo resp_rdata", resp_rdata, 32'h0);
    step();
    check("tmo idle", {31'h0, req_ready}, 32'h1);
    check("tmo pulse", {31'h0, resp_valid}, 32'h0);

    // Reset while in BUS drops the access
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_5004;
    req_wdata  = 32'h0BAD_F00D;
    step();
    req_valid = 1'b0;
    check("rbus mem_valid", {31'h0, mem_valid}, 32'h1);
    reset = 1'b1;
    mem_ready = 1'b1;
    step();
    reset = 1'b0;
    mem_ready = 1'b0;
    check("rbus mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rbus mem_addr", mem_addr, 32'h0);
    check("rbus mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rbus resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rbus req_ready", {31'h0, req_ready}, 32'h1);
    step();
    check("rbus no resp", {31'h0, resp_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
